// File: rtl/leaky_relu_derivative_parent.sv
// Backward pass of the two-column leaky ReLU: stores sign(H) per column in a mask FIFO
// and turns each incoming gradient into dL/dH using the stored mask and the shared leak factor.
module lrd_column #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] leak_factor,
  input  logic              clear,
  input  logic              h_valid,
  input  logic [DATA_W-1:0] h_data,
  input  logic              grad_valid,
  input  logic [DATA_W-1:0] grad_data,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic signed [2*DATA_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DEPTH-1:0] mask_mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             push_acc, pop_acc, overflow, underflow;
  logic signed [2*DATA_W-1:0] grad_ext, leak_ext, product, shifted;
  logic [DATA_W-1:0] scaled, result;

  // Handshake: a pop needs grad_valid and a non-empty FIFO; a push needs h_valid and
  // room, where room includes the slot freed by a same-cycle pop. No empty-FIFO bypass.
  always_comb begin
    pop_acc   = grad_valid && !empty;
    push_acc  = h_valid && (!full || pop_acc);
    overflow  = h_valid && full && !pop_acc;
    underflow = grad_valid && empty;
    count_nxt = count + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop_acc);
  end

  // Full-width product, floor shift, then saturate back to DATA_W.
  always_comb begin
    grad_ext = {{DATA_W{grad_data[DATA_W-1]}}, grad_data};
    leak_ext = {{DATA_W{leak_factor[DATA_W-1]}}, leak_factor};
    product  = grad_ext * leak_ext;
    shifted  = product >>> FRAC;
    if (shifted > SAT_MAX)      scaled = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[DATA_W-1:0];
    else                        scaled = shifted[DATA_W-1:0];
    result = mask_mem[rd_ptr] ? grad_data : scaled;
  end

  always_ff @(posedge clk) begin
    if (push_acc) mask_mem[wr_ptr] <= ($signed(h_data) > 0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= result;
      end
      valid_out <= pop_acc;
      count     <= count_nxt;
      full      <= (count_nxt == FULL_CNT);
      empty     <= (count_nxt == '0);
      if (overflow || underflow) err <= 1'b1;
    end
  end
endmodule

module leaky_relu_derivative_parent #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lrd_leak_factor_in,
  input  logic              lrd_clear_in,
  input  logic              lrd_h_valid_1_in,
  input  logic [DATA_W-1:0] lrd_h_data_1_in,
  input  logic              lrd_grad_valid_1_in,
  input  logic [DATA_W-1:0] lrd_grad_data_1_in,
  input  logic              lrd_h_valid_2_in,
  input  logic [DATA_W-1:0] lrd_h_data_2_in,
  input  logic              lrd_grad_valid_2_in,
  input  logic [DATA_W-1:0] lrd_grad_data_2_in,
  output logic [DATA_W-1:0] lrd_data_1_out,
  output logic              lrd_valid_1_out,
  output logic              lrd_full_1_out,
  output logic              lrd_empty_1_out,
  output logic              lrd_err_1_out,
  output logic [DATA_W-1:0] lrd_data_2_out,
  output logic              lrd_valid_2_out,
  output logic              lrd_full_2_out,
  output logic              lrd_empty_2_out,
  output logic              lrd_err_2_out
);
  lrd_column #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FRAC(FRAC)) u_col1 (
    .clk(clk), .rst(rst), .leak_factor(lrd_leak_factor_in), .clear(lrd_clear_in),
    .h_valid(lrd_h_valid_1_in), .h_data(lrd_h_data_1_in),
    .grad_valid(lrd_grad_valid_1_in), .grad_data(lrd_grad_data_1_in),
    .data_out(lrd_data_1_out), .valid_out(lrd_valid_1_out),
    .full(lrd_full_1_out), .empty(lrd_empty_1_out), .err(lrd_err_1_out)
  );

  lrd_column #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FRAC(FRAC)) u_col2 (
    .clk(clk), .rst(rst), .leak_factor(lrd_leak_factor_in), .clear(lrd_clear_in),
    .h_valid(lrd_h_valid_2_in), .h_data(lrd_h_data_2_in),
    .grad_valid(lrd_grad_valid_2_in), .grad_data(lrd_grad_data_2_in),
    .data_out(lrd_data_2_out), .valid_out(lrd_valid_2_out),
    .full(lrd_full_2_out), .empty(lrd_empty_2_out), .err(lrd_err_2_out)
  );
endmodule

// File: tb/tb_leaky_relu_derivative_parent.sv
// Bench for leaky_relu_derivative_parent: directed plan scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_leaky_relu_derivative_parent;
  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] leak;
  logic        clr;
  logic        hv[2], gv[2];
  logic [15:0] hd[2], gd[2];
  logic [15:0] dout[2];
  logic        vout[2], full[2], empty[2], err[2];

  leaky_relu_derivative_parent #(.DEPTH(DEPTH), .DATA_W(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .lrd_leak_factor_in(leak), .lrd_clear_in(clr),
    .lrd_h_valid_1_in(hv[0]), .lrd_h_data_1_in(hd[0]),
    .lrd_grad_valid_1_in(gv[0]), .lrd_grad_data_1_in(gd[0]),
    .lrd_h_valid_2_in(hv[1]), .lrd_h_data_2_in(hd[1]),
    .lrd_grad_valid_2_in(gv[1]), .lrd_grad_data_2_in(gd[1]),
    .lrd_data_1_out(dout[0]), .lrd_valid_1_out(vout[0]),
    .lrd_full_1_out(full[0]), .lrd_empty_1_out(empty[0]), .lrd_err_1_out(err[0]),
    .lrd_data_2_out(dout[1]), .lrd_valid_2_out(vout[1]),
    .lrd_full_2_out(full[1]), .lrd_empty_2_out(empty[1]), .lrd_err_2_out(err[1])
  );

  // scoreboard / reference model
  bit          q0[$], q1[$];
  logic [15:0] exp_data[2];
  bit          exp_valid[2], exp_err[2];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  // dL/dH for the leak slope: floor((g*l)/256) saturated to 16-bit signed
  function automatic logic [15:0] leaky(input logic [15:0] g, input logic [15:0] l);
    longint p, r, f;
    p = longint'($signed(g)) * longint'($signed(l));
    r = p % 256;
    if (r < 0) r += 256;
    f = (p - r) / 256;
    if (f > 32767) f = 32767;
    if (f < -32768) f = -32768;
    return f[15:0];
  endfunction

  task automatic model_col(ref bit q[$], input int c);
    int sz;
    bit pop_ok, push_ok, m;
    sz = q.size();
    if (clr) begin
      q.delete();
      exp_err[c] = 0;
      exp_valid[c] = 0;
      return;
    end
    pop_ok = gv[c] && sz > 0;
    push_ok = hv[c] && (sz < DEPTH || pop_ok);
    if (gv[c] && sz == 0) exp_err[c] = 1;
    if (hv[c] && !push_ok) exp_err[c] = 1;
    exp_valid[c] = pop_ok;
    if (pop_ok) begin
      m = q.pop_front();
      exp_data[c] = m ? gd[c] : leaky(gd[c], leak);
    end
    if (push_ok) q.push_back($signed(hd[c]) > 0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int c = 0; c < 2; c++) begin
      exp_data[c] = '0;
      exp_valid[c] = 0;
      exp_err[c] = 0;
    end
  endtask

  task automatic compare_all();
    int sz;
    for (int c = 0; c < 2; c++) begin
      sz = (c == 0) ? q0.size() : q1.size();
      check($sformatf("c%0d_valid", c+1), 32'(vout[c]), 32'(exp_valid[c]));
      check($sformatf("c%0d_data", c+1), 32'(dout[c]), 32'(exp_data[c]));
      check($sformatf("c%0d_full", c+1), 32'(full[c]), 32'(sz == DEPTH));
      check($sformatf("c%0d_empty", c+1), 32'(empty[c]), 32'(sz == 0));
      check($sformatf("c%0d_err", c+1), 32'(err[c]), 32'(exp_err[c]));
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_col(q0, 0);
      model_col(q1, 1);
    end
    #1;
    compare_all();
  endtask

  task automatic idle();
    clr = 0;
    for (int c = 0; c < 2; c++) begin
      hv[c] = 0; gv[c] = 0; hd[c] = '0; gd[c] = '0;
    end
  endtask

  task automatic push1(input int c, input logic [15:0] h);
    idle();
    hv[c] = 1; hd[c] = h;
    step();
  endtask

  task automatic pop1(input int c, input logic [15:0] g);
    idle();
    gv[c] = 1; gd[c] = g;
    step();
  endtask

  task automatic do_clear();
    idle();
    clr = 1;
    step();
    clr = 0;
  endtask

  initial begin
    rst = 0;
    leak = '0;
    idle();
    model_reset();
    step();
    step();
    check("reset_empty1", 32'(empty[0]), 32'd1);
    check("reset_valid2", 32'(vout[1]), 32'd0);
    rst = 1;

    // ordered passthrough
    leak = 16'h001A;
    push1(0, 16'h0100);
    push1(0, 16'hFF00);
    push1(0, 16'h0000);
    pop1(0, 16'h0200); check("pt_0", 32'(dout[0]), 32'h0200);
    pop1(0, 16'h0200); check("pt_1", 32'(dout[0]), 32'h0034);
    pop1(0, 16'h0200); check("pt_2", 32'(dout[0]), 32'h0034);
    idle(); step();
    check("pt_hold_valid", 32'(vout[0]), 32'd0);

    // saturation and floor
    push1(0, 16'hFF00);
    push1(0, 16'h8000);
    leak = 16'h0200;
    pop1(0, 16'h7FFF); check("sat_pos", 32'(dout[0]), 32'h7FFF);
    leak = 16'h0080;
    pop1(0, 16'hFFFF); check("floor_neg", 32'(dout[0]), 32'hFFFF);

    // full / overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) push1(0, 16'($urandom));
    check("ovf_full", 32'(full[0]), 32'd1);
    push1(0, 16'h0101);
    check("ovf_err", 32'(err[0]), 32'd1);
    leak = 16'($urandom);
    for (int i = 0; i < DEPTH; i++) pop1(0, 16'($urandom));
    check("drain_empty", 32'(empty[0]), 32'd1);
    do_clear();

    // push+pop at full, streamed through pointer wrap
    for (int i = 0; i < DEPTH; i++) push1(0, 16'($urandom));
    for (int i = 0; i < 20; i++) begin
      idle();
      hv[0] = 1; hd[0] = 16'($urandom);
      gv[0] = 1; gd[0] = 16'($urandom);
      step();
    end
    check("stream_full", 32'(full[0]), 32'd1);
    check("stream_err", 32'(err[0]), 32'd0);
    do_clear();

    // underflow on col2 while col1 streams
    for (int i = 0; i < 4; i++) begin
      idle();
      hv[0] = 1; hd[0] = 16'($urandom);
      gv[0] = (i > 0); gd[0] = 16'($urandom);
      gv[1] = 1; gd[1] = 16'($urandom);
      step();
      check("unf_valid2", 32'(vout[1]), 32'd0);
    end
    check("unf_err2", 32'(err[1]), 32'd1);
    check("unf_err1", 32'(err[0]), 32'd0);

    // clear with 5 entries and a concurrent push
    do_clear();
    for (int i = 0; i < 5; i++) push1(0, 16'($urandom));
    idle(); clr = 1; hv[0] = 1; hd[0] = 16'h0100;
    step();
    check("clr_empty", 32'(empty[0]), 32'd1);
    check("clr_err", 32'(err[0]), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      clr = ($urandom_range(0, 63) == 0);
      leak = 16'($urandom);
      for (int c = 0; c < 2; c++) begin
        hv[c] = $urandom_range(0, 1);
        hd[c] = 16'($urandom);
        gv[c] = $urandom_range(0, 1);
        gd[c] = 16'($urandom);
      end
      step();
    end

    // asynchronous reset mid-stream
    idle();
    for (int i = 0; i < 4; i++) push1(1, 16'($urandom));
    idle(); hv[0] = 1; hd[0] = 16'h0100; gv[1] = 1; gd[1] = 16'h1234;
    #3;
    rst = 0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("arst_data%0d", c+1), 32'(dout[c]), 32'd0);
      check($sformatf("arst_valid%0d", c+1), 32'(vout[c]), 32'd0);
      check($sformatf("arst_empty%0d", c+1), 32'(empty[c]), 32'd1);
      check($sformatf("arst_err%0d", c+1), 32'(err[c]), 32'd0);
    end
    step();
    rst = 1;
    pop1(1, 16'h0400);
    check("post_rst_unf", 32'(err[1]), 32'd1);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/leaky_relu_derivative_parent.md
Name: leaky_relu_derivative_parent

Overview:
- Backward-pass counterpart of the two-column leaky ReLU forward stage.
- Captures the sign of each forward pre-activation (H) per column into a mask FIFO.
- On the backward pass, consumes incoming gradients in the same order and emits dL/dH:
  - gradient passed through when the stored H was positive;
  - gradient scaled by the leak factor otherwise.
- Sits between the loss/gradient path and the systolic array's weight-update path; two independent columns.

Parameters:
- DEPTH, 8, mask FIFO entries per column (power of two, ≥2).
- DATA_W, 16, signed fixed-point data width.
- FRAC, 8, fractional bits (Q8.8 at defaults).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- lrd_leak_factor_in  input  DATA_W  signed leak factor, Q(FRAC); shared by both columns.
- lrd_clear_in  input  1  synchronous flush of both columns.
- lrd_h_valid_{1,2}_in  input  1  forward H sample valid, per column.
- lrd_h_data_{1,2}_in  input  DATA_W  signed forward pre-activation H.
- lrd_grad_valid_{1,2}_in  input  1  incoming gradient valid.
- lrd_grad_data_{1,2}_in  input  DATA_W  signed incoming gradient dL/dA.
- lrd_data_{1,2}_out  output  DATA_W  signed dL/dH.
- lrd_valid_{1,2}_out  output  1  output valid.
- lrd_full_{1,2}_out  output  1  mask FIFO holds DEPTH entries.
- lrd_empty_{1,2}_out  output  1  mask FIFO holds 0 entries.
- lrd_err_{1,2}_out  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, async):
  - all data/valid/err outputs 0; full=0, empty=1;
  - FIFO pointers and counts 0.
- Column independence: columns share only clk, rst, leak factor and clear; no cross-column interaction.
- Mask FIFO: 1 bit per entry, mask = (H > 0). H == 0 and H < 0 store 0, i.e. the leak slope applies.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count has log2(DEPTH)+1 bits.
- full/empty: registered, derived from next-state count.
- Push: accepted when h_valid=1 and (full=0 or a pop is accepted the same cycle).
  - h_valid=1 with full=1 and no pop → sample dropped, err set.
- Pop: accepted when grad_valid=1 and empty=0.
  - grad_valid=1 with empty=1 → no pop, no output (valid_out=0 next cycle), err set.
  - No bypass: a push and pop in the same cycle on an empty FIFO is an underflow; the push is still accepted.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Output latency: exactly 1 cycle. On an accepted pop in cycle N, at cycle N+1:
  - valid_out=1;
  - data_out = grad when mask=1, else sat(floor((grad × leak) / 2^FRAC)).
  - The product is full 2·DATA_W signed. Divide by 2^FRAC with an arithmetic right shift (floor), then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - The leak factor used is the value present in cycle N.
- Hold behaviour: valid_out=0 in any cycle without a preceding accepted pop; data_out holds its last value.
- Back-to-back pops give one valid output per cycle.
- err:
  - sticky; cleared only by rst or lrd_clear_in;
  - set the cycle after the offending event;
  - an overflow or underflow does not corrupt stored entries.
- lrd_clear_in=1: next cycle both FIFOs empty, err=0, valid_out=0.
  - Clear takes priority over any push/pop in the same cycle, and those events do not set err.
  - data_out is held.
- Reset mid-operation: all entries discarded immediately; no output is produced for gradients presented during reset.

Test Plan:
- Ordered passthrough: col1 push H = 0x0100, 0xFF00, 0x0000. Then grads 0x0200 ×3 with leak = 0x001A (≈0.1). Expect outputs 0x0200, 0x0034, 0x0034, each 1 cycle after its grad, valid for 3 consecutive cycles.
- Saturation and floor:
  - mask 0, grad = 0x7FFF, leak = 0x0200 (2.0) → 0x7FFF;
  - grad = 0xFFFF (−1 LSB), leak = 0x0080 (0.5) → 0xFFFF (floor).
- Full/overflow: push 8 samples → full=1. A 9th push alone is dropped and err=1. Then 8 pops return the original 8 masks in order, and empty=1 after the last pop.
- Simultaneous push+pop at full: count stays 8, full stays 1, err stays 0. Order is preserved across pointer wrap (16+ entries streamed).
- Underflow and independence: col2 grad_valid while empty → valid_2_out=0, err_2=1. Meanwhile col1 traffic is unaffected and err_1 stays 0.
- Clear and reset:
  - lrd_clear_in with 5 entries plus a concurrent push → next cycle empty=1, err=0.
  - Assert rst asynchronously mid-stream → all outputs 0 and empty=1 immediately, with no clock edge needed.
